// File: rtl/tl_d_queue_if.sv
// TileLink D-channel queue port bundle: enqueue side, dequeue side and occupancy.
// The queue takes the slave modport; the producer/consumer pair takes master.
interface tl_d_queue_if #(
    parameter int ENTRIES  = 2,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 11,
    parameter int SINK_W   = 1,
    parameter int SIZE_W   = 2
);
    localparam int COUNT_W = $clog2(ENTRIES + 1);

    // A beat moves on a side exactly when its valid and ready are both high at the
    // rising clock edge; valid never waits on ready, and bits are held while valid.
    logic                io_enq_valid;
    logic                io_enq_ready;
    logic [2:0]          io_enq_bits_opcode;
    logic [1:0]          io_enq_bits_param;
    logic [SIZE_W-1:0]   io_enq_bits_size;
    logic [SOURCE_W-1:0] io_enq_bits_source;
    logic [SINK_W-1:0]   io_enq_bits_sink;
    logic                io_enq_bits_denied;
    logic [DATA_W-1:0]   io_enq_bits_data;
    logic                io_enq_bits_corrupt;

    logic                io_deq_valid;
    logic                io_deq_ready;
    logic [2:0]          io_deq_bits_opcode;
    logic [1:0]          io_deq_bits_param;
    logic [SIZE_W-1:0]   io_deq_bits_size;
    logic [SOURCE_W-1:0] io_deq_bits_source;
    logic [SINK_W-1:0]   io_deq_bits_sink;
    logic                io_deq_bits_denied;
    logic [DATA_W-1:0]   io_deq_bits_data;
    logic                io_deq_bits_corrupt;

    logic [COUNT_W-1:0]  io_count;

    modport slave (
        input  io_enq_valid, io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
               io_enq_bits_source, io_enq_bits_sink, io_enq_bits_denied,
               io_enq_bits_data, io_enq_bits_corrupt, io_deq_ready,
        output io_enq_ready, io_deq_valid, io_deq_bits_opcode, io_deq_bits_param,
               io_deq_bits_size, io_deq_bits_source, io_deq_bits_sink,
               io_deq_bits_denied, io_deq_bits_data, io_deq_bits_corrupt, io_count
    );

    modport master (
        output io_enq_valid, io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
               io_enq_bits_source, io_enq_bits_sink, io_enq_bits_denied,
               io_enq_bits_data, io_enq_bits_corrupt, io_deq_ready,
        input  io_enq_ready, io_deq_valid, io_deq_bits_opcode, io_deq_bits_param,
               io_deq_bits_size, io_deq_bits_source, io_deq_bits_sink,
               io_deq_bits_denied, io_deq_bits_data, io_deq_bits_corrupt, io_count
    );
endinterface

// File: rtl/tl_d_queue.sv
// Circular TileLink D-channel buffer of ENTRIES slots carrying every D field,
// with optional flow-through (FLOW) and full-queue pass-through ready (PIPE).
module tl_d_queue #(
    parameter int ENTRIES  = 2,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 11,
    parameter int SINK_W   = 1,
    parameter int SIZE_W   = 2,
    parameter int FLOW     = 0,
    parameter int PIPE     = 0
) (
    input  logic          clock,
    input  logic          reset,
    tl_d_queue_if.slave   io
);
    localparam int   PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int   COUNT_W = $clog2(ENTRIES + 1);
    localparam int   WORD_W  = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1;
    localparam logic FLOW_B  = (FLOW != 0);
    localparam logic PIPE_B  = (PIPE != 0);

    logic [PTR_W-1:0]   r_enq_ptr;
    logic [PTR_W-1:0]   r_deq_ptr;
    logic               r_maybe_full;
    logic [WORD_W-1:0]  r_mem [ENTRIES];

    logic               w_ptr_match;
    logic               w_empty;
    logic               w_full;
    logic               w_bypass;
    logic               w_enq_ready;
    logic               w_deq_valid;
    logic               w_do_enq;
    logic               w_do_deq;
    logic [PTR_W-1:0]   w_enq_ptr_nxt;
    logic [PTR_W-1:0]   w_deq_ptr_nxt;
    logic [WORD_W-1:0]  w_enq_word;
    logic [WORD_W-1:0]  w_deq_word;
    logic [COUNT_W-1:0] w_count;

    assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
    assign w_empty     = w_ptr_match & ~r_maybe_full;
    assign w_full      = w_ptr_match & r_maybe_full;

    // Flow-through on an empty queue: a beat taken by the consumer the same cycle
    // never touches storage or pointers.
    assign w_bypass    = FLOW_B & w_empty;
    assign w_enq_ready = ~w_full | (PIPE_B & io.io_deq_ready);
    assign w_deq_valid = ~w_empty | (FLOW_B & io.io_enq_valid);
    assign w_do_enq    = io.io_enq_valid & w_enq_ready & ~(w_bypass & io.io_deq_ready);
    assign w_do_deq    = w_deq_valid & io.io_deq_ready & ~w_bypass;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    assign w_enq_ptr_nxt = (r_enq_ptr == PTR_W'(ENTRIES - 1)) ? '0 : r_enq_ptr + 1'b1;
    assign w_deq_ptr_nxt = (r_deq_ptr == PTR_W'(ENTRIES - 1)) ? '0 : r_deq_ptr + 1'b1;

    assign w_enq_word = {io.io_enq_bits_opcode, io.io_enq_bits_param, io.io_enq_bits_size,
                         io.io_enq_bits_source, io.io_enq_bits_sink, io.io_enq_bits_denied,
                         io.io_enq_bits_data, io.io_enq_bits_corrupt};
    assign w_deq_word = w_bypass ? w_enq_word : r_mem[r_deq_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_do_enq) r_enq_ptr <= w_enq_ptr_nxt;
            if (w_do_deq) r_deq_ptr <= w_deq_ptr_nxt;
            if (w_do_enq != w_do_deq) r_maybe_full <= w_do_enq;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_enq) r_mem[r_enq_ptr] <= w_enq_word;
    end

    always_comb begin
        w_count = '0;
        if (w_ptr_match)
            w_count = r_maybe_full ? COUNT_W'(ENTRIES) : '0;
        else if (r_enq_ptr > r_deq_ptr)
            w_count = COUNT_W'(r_enq_ptr) - COUNT_W'(r_deq_ptr);
        else
            w_count = COUNT_W'(ENTRIES) + COUNT_W'(r_enq_ptr) - COUNT_W'(r_deq_ptr);
    end

    assign io.io_enq_ready = w_enq_ready;
    assign io.io_deq_valid = w_deq_valid;
    assign io.io_count     = w_count;
    assign {io.io_deq_bits_opcode, io.io_deq_bits_param, io.io_deq_bits_size,
            io.io_deq_bits_source, io.io_deq_bits_sink, io.io_deq_bits_denied,
            io.io_deq_bits_data, io.io_deq_bits_corrupt} = w_deq_word;
endmodule
